// File: rtl/dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// dma_priority_arbiter
//
// Priority and handshake controller for four DMA channels. It merges software
// request bits and hardware DREQ lines into one effective request vector. It
// then selects a channel by fixed or rotating priority. For that channel it
// runs the HRQ/HLDA bus-hold handshake and drives the one-hot DACK until EOP.
//
// Ports
//   CLK             system clock, all state on posedge
//   Reset           asynchronous active-low reset
//   Request[2:0]    [2] set(1)/clear(0) value, [1:0] channel index
//   request_writed  write strobe for Request
//   DREQ[3:0]       hardware channel requests
//   DREQ_Sense      0: DREQ active-high, 1: DREQ active-low
//   Mask[3:0]       1 = hardware request of that channel is masked
//   Rotate          0: fixed priority (ch0 highest), 1: rotating priority
//   HLDA            hold acknowledge from the CPU
//   EOP             end of service of the active channel
//   HRQ             hold request to the CPU
//   DACK[3:0]       one-hot channel acknowledge, only during service
//   Active_Channel  selected channel index
//   Channel_Valid   high while Active_Channel is being requested or served
//   Sw_Pending[3:0] pending software request bits
// ---------------------------------------------------------------------------
module dma_priority_arbiter #(
  parameter int NCH = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [2:0] Request,
  input  logic       request_writed,
  input  logic [3:0] DREQ,
  input  logic       DREQ_Sense,
  input  logic [3:0] Mask,
  input  logic       Rotate,
  input  logic       HLDA,
  input  logic       EOP,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic [1:0] Active_Channel,
  output logic       Channel_Valid,
  output logic [3:0] Sw_Pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    SERVE = 2'b10
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] hw_req;
  logic [3:0] eff_req;
  logic [1:0] base;
  logic [1:0] winner;
  logic [3:0] sw_next;

  // The search starts at base and wraps modulo 4. The first requesting channel wins.
  function automatic logic [1:0] pick_winner(input logic [3:0] req,
                                             input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    pick_winner = start;
    found       = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = start + 2'(k);
      if (!found && req[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Build the effective request vector and the candidate winner.
  // Software bits bypass the mask.
  always_comb begin
    hw_req  = DREQ ^ {4{DREQ_Sense}};
    eff_req = (hw_req & ~Mask) | Sw_Pending;
    if (Rotate) begin
      base = ptr;
    end else begin
      base = 2'd0;
    end
    winner = pick_winner(eff_req, base);
  end

  // Next software bits: EOP clears the bit of the served channel. A write is
  // applied afterwards, so a set write on the same edge overrides the clear.
  always_comb begin
    sw_next = Sw_Pending;
    if ((state == SERVE) && EOP) begin
      sw_next[Active_Channel] = 1'b0;
    end else begin
      sw_next = sw_next;
    end
    if (request_writed) begin
      sw_next[Request[1:0]] = Request[2];
    end else begin
      sw_next = sw_next;
    end
  end

  // Handshake FSM with registered outputs, software bits and priority pointer.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state          <= IDLE;
      ptr            <= 2'd0;
      HRQ            <= 1'b0;
      DACK           <= 4'b0000;
      Active_Channel <= 2'd0;
      Channel_Valid  <= 1'b0;
      Sw_Pending     <= 4'b0000;
    end else begin
      Sw_Pending <= sw_next;
      case (state)
        IDLE: begin
          // A still-high HLDA from the previous service blocks a new request.
          if ((eff_req != 4'b0000) && !HLDA) begin
            Active_Channel <= winner;
            HRQ            <= 1'b1;
            Channel_Valid  <= 1'b1;
            state          <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          // The latched channel is kept and is not re-arbitrated. It is
          // dropped only if its own request goes away.
          if (!eff_req[Active_Channel]) begin
            HRQ           <= 1'b0;
            Channel_Valid <= 1'b0;
            state         <= IDLE;
          end else if (HLDA) begin
            DACK  <= 4'b0001 << Active_Channel;
            state <= SERVE;
          end else begin
            state <= REQ;
          end
        end
        SERVE: begin
          if (EOP) begin
            DACK          <= 4'b0000;
            HRQ           <= 1'b0;
            Channel_Valid <= 1'b0;
            if (Rotate) begin
              ptr <= Active_Channel + 2'd1;
            end else begin
              ptr <= ptr;
            end
            state <= IDLE;
          end else if (!HLDA) begin
            // Preemption: end the service without touching the pointer
            // or the software bits.
            DACK          <= 4'b0000;
            HRQ           <= 1'b0;
            Channel_Valid <= 1'b0;
            state         <= IDLE;
          end else begin
            state <= SERVE;
          end
        end
        default: begin
          DACK          <= 4'b0000;
          HRQ           <= 1'b0;
          Channel_Valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [2:0] Request;
  logic       request_writed;
  logic [3:0] DREQ;
  logic       DREQ_Sense;
  logic [3:0] Mask;
  logic       Rotate;
  logic       HLDA;
  logic       EOP;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] Active_Channel;
  logic       Channel_Valid;
  logic [3:0] Sw_Pending;

  int compared = 0;
  int mismatched = 0;

  // Reference model state.
  bit [3:0] m_sw;
  int       m_ptr;
  bit       m_waiting;   // hold requested, no acknowledge yet
  bit       m_serving;   // channel m_ch acknowledged
  int       m_ch;

  dma_priority_arbiter dut (
    .CLK(CLK), .Reset(Reset), .Request(Request), .request_writed(request_writed),
    .DREQ(DREQ), .DREQ_Sense(DREQ_Sense), .Mask(Mask), .Rotate(Rotate),
    .HLDA(HLDA), .EOP(EOP), .HRQ(HRQ), .DACK(DACK), .Active_Channel(Active_Channel),
    .Channel_Valid(Channel_Valid), .Sw_Pending(Sw_Pending)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit [3:0] e, input int start);
    for (int k = 0; k < 4; k++) begin
      if (e[(start + k) % 4]) return (start + k) % 4;
    end
    return start;
  endfunction

  task automatic model_reset();
    m_sw = 4'b0000; m_ptr = 0; m_waiting = 1'b0; m_serving = 1'b0; m_ch = 0;
  endtask

  task automatic model_edge();
    bit [3:0] hw, eff, nsw;
    hw  = DREQ ^ {4{DREQ_Sense}};
    eff = (hw & ~Mask) | m_sw;
    nsw = m_sw;
    if (m_serving) begin
      if (EOP) begin
        nsw[m_ch] = 1'b0;
        m_serving = 1'b0;
        if (Rotate) m_ptr = (m_ch + 1) % 4;
      end else if (!HLDA) begin
        m_serving = 1'b0;
      end
    end else if (m_waiting) begin
      if (!eff[m_ch]) m_waiting = 1'b0;
      else if (HLDA) begin m_waiting = 1'b0; m_serving = 1'b1; end
    end else if (eff != 4'b0000 && !HLDA) begin
      m_ch = pick(eff, Rotate ? m_ptr : 0);
      m_waiting = 1'b1;
    end
    if (request_writed) nsw[Request[1:0]] = Request[2];
    m_sw = nsw;
  endtask

  task automatic check_all();
    bit [3:0] exp_dack;
    exp_dack = m_serving ? (4'b0001 << m_ch) : 4'b0000;
    chk("hrq", {3'b000, HRQ}, {3'b000, (m_waiting | m_serving)});
    chk("dack", DACK, exp_dack);
    chk("valid", {3'b000, Channel_Valid}, {3'b000, (m_waiting | m_serving)});
    chk("sw_pending", Sw_Pending, m_sw);
    if (m_waiting || m_serving) chk("active_channel", {2'b00, Active_Channel}, 4'(m_ch));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [3:0] d, input logic [3:0] m, input logic s,
                       input logic r, input logic h, input logic e);
    DREQ = d; Mask = m; DREQ_Sense = s; Rotate = r; HLDA = h; EOP = e;
  endtask

  initial begin
    Reset = 1'b0; Request = 3'b000; request_writed = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #3;
    check_all();
    chk("reset_ac", {2'b00, Active_Channel}, 4'b0000);
    #9 Reset = 1'b1;

    // Fixed priority: ch1 beats ch3, then ch3 once ch1 is gone.
    drive(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("fix_hrq", {3'b000, HRQ}, 4'b0001);
    HLDA = 1'b1; step();
    chk("fix_dack1", DACK, 4'b0010);
    chk("fix_ac1", {2'b00, Active_Channel}, 4'b0001);
    EOP = 1'b1; DREQ = 4'b1000; step();
    chk("fix_eop", DACK, 4'b0000);
    EOP = 1'b0; step();                 // HLDA still high: stays idle
    HLDA = 1'b0; step();
    HLDA = 1'b1; step();
    chk("fix_dack3", DACK, 4'b1000);
    EOP = 1'b1; DREQ = 4'b0000; step();

    // Rotating priority with all channels requesting.
    drive(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      HLDA = 1'b0; EOP = 1'b0; step();
      HLDA = 1'b1; step();
      chk("rot_order", DACK, 4'b0001 << (i % 4));
      EOP = 1'b1; step();
    end

    // Masked hardware requests. Software request ch2 bypasses the mask.
    drive(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("mask_hrq", {3'b000, HRQ}, 4'b0000);
    Request = 3'b110; request_writed = 1'b1; step();
    chk("sw_set", Sw_Pending, 4'b0100);
    request_writed = 1'b0; step();
    HLDA = 1'b1; step();
    chk("sw_dack", DACK, 4'b0100);
    EOP = 1'b1; step();
    chk("sw_clear", Sw_Pending, 4'b0000);

    // Withdrawal in REQ, then preemption in SERVE.
    drive(4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    DREQ = 4'b0000; step();
    chk("withdraw_hrq", {3'b000, HRQ}, 4'b0000);
    DREQ = 4'b0100; step();
    HLDA = 1'b1; step();
    HLDA = 1'b0; step();
    chk("preempt_dack", DACK, 4'b0000);
    DREQ = 4'b0011; step();             // pointer still 1 -> ch1
    chk("preempt_ptr", {2'b00, Active_Channel}, 4'b0001);
    HLDA = 1'b1; step();
    EOP = 1'b1; step();                 // pointer -> 2

    // Active-low sense, and a set write that collides with EOP.
    drive(4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    HLDA = 1'b1; step();
    chk("sense_dack", DACK, 4'b0001);
    EOP = 1'b1; step();
    drive(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    Request = 3'b110; request_writed = 1'b1; step();
    request_writed = 1'b0; step();
    HLDA = 1'b1; step();
    EOP = 1'b1; request_writed = 1'b1; step();
    chk("set_wins", {3'b000, Sw_Pending[2]}, 4'b0001);
    EOP = 1'b0; request_writed = 1'b0; HLDA = 1'b0; step();
    HLDA = 1'b1; step();
    chk("reset_pre_dack", DACK, 4'b0100);

    // Asynchronous reset while serving. The pointer (2) must return to 0.
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_dack", DACK, 4'b0000);
    drive(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    #3 Reset = 1'b1;
    step();
    chk("reset_ptr", {2'b00, Active_Channel}, 4'b0000);

    // Randomised traffic against the model.
    for (int n = 0; n < 800; n++) begin
      DREQ = 4'($urandom); Mask = 4'($urandom); DREQ_Sense = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) Rotate = ~Rotate;
      request_writed = ($urandom_range(0, 5) == 0);
      Request = 3'($urandom);
      if (m_serving) begin
        HLDA = ($urandom_range(0, 7) != 0);
        EOP  = ($urandom_range(0, 2) == 0);
      end else if (m_waiting) begin
        HLDA = ($urandom_range(0, 1) == 0);
        EOP  = ($urandom_range(0, 7) == 0);
      end else begin
        HLDA = ($urandom_range(0, 3) == 0);
        EOP  = ($urandom_range(0, 7) == 0);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
